controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Parameter HALF_BIT, default 60, is the length in SYSCLK cycles of one half shift-clock period (6 us at 10 MHz); it SHALL be at least 4.
REQ-002 Parameter POLL_CYCLES, default 166667, is the number of SYSCLK cycles from one frame start to the next (about 60 Hz); it SHALL be greater than 16*HALF_BIT.
REQ-003 SYSCLK  input  1  system clock (10 MHz); all state SHALL change on its rising edge.
REQ-004 NSYSRESET  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 contREAD  input  1  serial, active-low button data from the external game controller; asynchronous to SYSCLK.
REQ-006 contWRITE  output  2  controller drive signals: bit 1 = latch, bit 0 = shift clock.
REQ-007 RDATA  output  8  parallel button state; 1 = pressed; bit k = serial bit k (bit 0 first).

Function
REQ-008 contREAD SHALL pass through a 2-flop synchronizer; "sample" below always means the synchronized value.
REQ-009 FSM states SHALL be: IDLE, LATCH_HI, LATCH_LO, CLK_HI, CLK_LO.
REQ-010 Each of LATCH_HI, LATCH_LO, CLK_HI and CLK_LO SHALL last exactly HALF_BIT cycles.
REQ-011 In LATCH_HI, contWRITE SHALL be 2'b10; in CLK_HI it SHALL be 2'b01; in every other state it SHALL be 2'b00.
REQ-012 Frame sequence: IDLE -> LATCH_HI -> LATCH_LO -> (CLK_HI -> CLK_LO) x7 -> IDLE; total frame length 16*HALF_BIT cycles.
REQ-013 Bit 0 SHALL be sampled on the last cycle of LATCH_LO.
REQ-014 Bit k (k = 1..7) SHALL be sampled on the last cycle of the k-th CLK_LO.
REQ-015 Each sample SHALL be stored inverted into a shadow shift register.
REQ-016 RDATA SHALL load the full shadow value at the same edge that samples bit 7, so it becomes visible on the next cycle.
REQ-017 RDATA SHALL hold its value between updates and SHALL never show a partially collected frame.
REQ-018 A free-running poll counter SHALL start a frame every POLL_CYCLES cycles.
REQ-019 The first frame (LATCH_HI) SHALL begin on the first rising edge after NSYSRESET deasserts.
REQ-020 A poll tick that occurs while a frame is in progress is impossible by REQ-002 and needs no handling.
REQ-021 Bit counter width SHALL be 3 bits. The phase counter SHALL be sized for HALF_BIT, and the poll counter for POLL_CYCLES.

Reset
REQ-022 While NSYSRESET = 0, the block SHALL immediately and asynchronously force: contWRITE = 2'b00, RDATA = 8'h00, shadow register = 0, synchronizer = 1 (idle-high line), all counters = 0, state = IDLE.
REQ-023 Reset asserted mid-frame SHALL abort the frame without updating RDATA; after release, a new frame starts per REQ-019.

Structure
REQ-024 Package controller_pkg SHALL hold the FSM state enum typedef and the default HALF_BIT and POLL_CYCLES constants.
REQ-025 The 2-flop synchronizer SHALL be a separate sub-module, cont_sync (1-bit data in, clock, async active-low reset, reset value 1).
REQ-026 The FSM, counters and data path SHALL reside in controller.

Verification (HALF_BIT = 4, POLL_CYCLES = 100, SYSCLK period 100 ns)
REQ-027 Reset: hold NSYSRESET = 0 with contREAD toggling -> contWRITE = 2'b00 and RDATA = 8'h00 throughout.
REQ-028 Timing: release reset, contREAD = 1 -> latch high cycles 1-4, low cycles 5-8, then seven shift-clock pulses (4 high, 4 low each); RDATA = 8'h00 after the frame; second latch rise exactly 100 cycles after the first.
REQ-029 Pattern: drive contREAD = ~bit k of 8'hA5, changing 1 cycle after each shift-clock rise (bit 0 before latch low) -> RDATA = 8'hA5 from cycle 16*4+1 after frame start, stable until the next frame end.
REQ-030 All pressed: contREAD held 0 -> RDATA = 8'hFF after first frame; then contREAD held 1 -> RDATA = 8'h00 after next frame.
REQ-031 Mid-frame reset: after RDATA = 8'hA5, pulse NSYSRESET low during the 3rd shift-clock pulse -> outputs zero asynchronously; after release a fresh frame starts on the first edge and RDATA is updated only at its end.

Source files
------------

// File: rtl/controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : controller_pkg
// Purpose  : Shared types and defaults for the serial game-controller reader:
//            FSM state encoding, default timing constants and the per-state
//            drive decode for the latch / shift-clock lines.
// Revision : 1.0 - initial release
// ============================================================================
package controller_pkg;

  // One half shift-clock period in SYSCLK cycles (6 us at 10 MHz)
  localparam int c_default_half_bit    = 60;
  // SYSCLK cycles between frame starts (about 60 Hz at 10 MHz)
  localparam int c_default_poll_cycles = 166667;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH_HI = 3'd1,
    LATCH_LO = 3'd2,
    CLK_HI   = 3'd3,
    CLK_LO   = 3'd4
  } state_t;

  // Controller drive pattern for a state: bit 1 = latch, bit 0 = shift clock
  function automatic logic [1:0] write_for(input state_t s);
    logic [1:0] w;
    w = 2'b00;
    case (s)
      LATCH_HI: w = 2'b10;
      CLK_HI:   w = 2'b01;
      default:  w = 2'b00;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cont_sync.sv
`default_nettype none
// ============================================================================
// Module   : cont_sync
// Purpose  : Two-flop synchronizer for the asynchronous controller data line.
//            Resets to 1 because the serial line idles high.
// Revision : 1.0 - initial release
// ============================================================================
module cont_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage resynchronisation into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/controller.sv
`default_nettype none
// ============================================================================
// Module   : controller
// Purpose  : Periodically polls an 8-button serial game controller. Each
//            frame raises latch for one half period, then issues seven shift
//            clock pulses, collecting eight active-low bits which are
//            published inverted on RDATA once the whole frame is in.
// Revision : 1.0 - initial release
// ============================================================================
module controller
  import controller_pkg::*;
#(
  parameter int HALF_BIT    = c_default_half_bit,
  parameter int POLL_CYCLES = c_default_poll_cycles
) (
  input  logic       SYSCLK,
  input  logic       NSYSRESET,
  input  logic       contREAD,
  output logic [1:0] contWRITE,
  output logic [7:0] RDATA
);

  localparam int c_phase_w = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
  localparam int c_poll_w  = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [c_phase_w-1:0] c_phase_last = c_phase_w'(HALF_BIT - 1);
  localparam logic [c_poll_w-1:0]  c_poll_last  = c_poll_w'(POLL_CYCLES - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [c_phase_w-1:0] r_phase;
  logic [2:0]           r_bit;
  logic [c_poll_w-1:0]  r_poll;
  logic [7:0]           r_shadow;
  logic [7:0]           r_rdata;
  logic [1:0]           r_write;

  logic                 w_sample;
  logic                 w_phase_end;
  logic                 w_tick;
  logic                 w_capture;
  logic                 w_last_bit;
  logic [7:0]           w_shadow_next;

  cont_sync u_sync (
    .clk   (SYSCLK),
    .rst_n (NSYSRESET),
    .i_d   (contREAD),
    .o_q   (w_sample)
  );

  assign w_phase_end   = (r_phase == c_phase_last);
  // Counter sits at zero right out of reset, so the first frame starts on
  // the first edge after release.
  assign w_tick        = (r_poll == '0);
  // r_bit holds k during the k-th CLK_LO; 7 marks the final bit of the frame
  assign w_last_bit    = (r_bit == 3'd7);
  assign w_capture     = w_phase_end && ((r_state == LATCH_LO) || (r_state == CLK_LO));
  // Bits arrive LSB first: shift in at the top so bit 0 ends up at position 0
  assign w_shadow_next = {~w_sample, r_shadow[7:1]};

  // Free-running frame-rate counter
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET)              r_poll <= '0;
    else if (r_poll == c_poll_last) r_poll <= '0;
    else                         r_poll <= r_poll + 1'b1;
  end

  // FSM state register
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) r_state <= IDLE;
    else            r_state <= w_next_state;
  end

  // Next-state decode: every active state lasts one half period
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (w_tick)      w_next_state = LATCH_HI;
      LATCH_HI: if (w_phase_end) w_next_state = LATCH_LO;
      LATCH_LO: if (w_phase_end) w_next_state = CLK_HI;
      CLK_HI:   if (w_phase_end) w_next_state = CLK_LO;
      CLK_LO:   if (w_phase_end) w_next_state = w_last_bit ? IDLE : CLK_HI;
      default:                   w_next_state = IDLE;
    endcase
  end

  // Half-period phase counter, restarted on every state change
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET)                         r_phase <= '0;
    else if (r_state == IDLE || w_phase_end) r_phase <= '0;
    else                                    r_phase <= r_phase + 1'b1;
  end

  // Bit index: 1 entering the first shift pulse, advancing per CLK_LO
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET)                                 r_bit <= 3'd0;
    else if (r_state == IDLE)                       r_bit <= 3'd0;
    else if (w_phase_end && r_state == LATCH_LO)    r_bit <= 3'd1;
    else if (w_phase_end && r_state == CLK_LO)      r_bit <= r_bit + 3'd1;
  end

  // Shadow register collects inverted samples during the frame
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET)     r_shadow <= 8'h00;
    else if (w_capture) r_shadow <= w_shadow_next;
  end

  // Publish the whole frame at once on the edge that samples bit 7
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET)                                      r_rdata <= 8'h00;
    else if (w_capture && r_state == CLK_LO && w_last_bit) r_rdata <= w_shadow_next;
  end

  // Registered line drive so the pad outputs are glitch-free
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) r_write <= 2'b00;
    else            r_write <= write_for(w_next_state);
  end

  assign contWRITE = r_write;
  assign RDATA     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_controller
// Purpose  : Self-checking bench for controller. A cycle-offset timing model
//            predicts latch/shift-clock drive; a per-frame byte model predicts
//            RDATA. Includes reset-hold, fixed patterns, random bytes and a
//            mid-frame asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_controller;

  localparam int HB = 4;
  localparam int PC = 100;
  localparam int N_FRAMES = 13;
  localparam int RST_FRAME = 5;

  logic       SYSCLK = 1'b0;
  logic       NSYSRESET = 1'b0;
  logic       contREAD = 1'b1;
  logic [1:0] contWRITE;
  logic [7:0] RDATA;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         t;
  int         o;
  int         frame;
  logic [7:0] cur_byte;
  logic [7:0] exp_rdata;

  controller #(.HALF_BIT(HB), .POLL_CYCLES(PC)) dut (
    .SYSCLK    (SYSCLK),
    .NSYSRESET (NSYSRESET),
    .contREAD  (contREAD),
    .contWRITE (contWRITE),
    .RDATA     (RDATA)
  );

  always #50 SYSCLK = ~SYSCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d frame=%0d)", tag, got, exp, t, frame);
    end
  endtask

  // Expected drive at cycle offset oo within a frame (0 = first latch cycle)
  function automatic logic [1:0] exp_write(input int oo);
    if (oo < 2*HB)  return (oo < HB) ? 2'b10 : 2'b00;
    if (oo < 16*HB) return (((oo - 2*HB) % (2*HB)) < HB) ? 2'b01 : 2'b00;
    return 2'b00;
  endfunction

  function automatic logic [7:0] byte_for(input int f);
    case (f)
      0: return 8'h00;
      1: return 8'hA5;
      2: return 8'hFF;
      3: return 8'h00;
      4: return 8'hA5;
      default: return 8'($urandom_range(255));
    endcase
  endfunction

  // One clock: check outputs #1 after the edge, then drive the next stimulus
  task automatic cycle();
    logic [7:0] b;
    @(posedge SYSCLK);
    #1;
    if (!NSYSRESET) begin
      check("rst_write", 32'(contWRITE), 32'd0);
      check("rst_rdata", 32'(RDATA), 32'd0);
    end else begin
      t++;
      o = (t - 1) % PC;
      if (o == 16*HB) exp_rdata = cur_byte;
      check("write", 32'(contWRITE), 32'(exp_write(o)));
      check("rdata", 32'(RDATA), 32'(exp_rdata));
      // Bit k changes one cycle after the k-th shift-clock rise
      if (o > 2*HB && o < 16*HB && (o % (2*HB)) == 1) begin
        b = cur_byte;
        contREAD = ~b[(o - 1) / (2*HB)];
      end
      // Present bit 0 of the next frame well before its latch
      if (o == 16*HB + 16) begin
        frame++;
        cur_byte = byte_for(frame);
        b = cur_byte;
        contREAD = ~b[0];
      end
    end
  endtask

  initial begin
    logic [7:0] b;
    t = 0; o = 0; frame = 0; exp_rdata = 8'h00; cur_byte = 8'h00;
    // Held reset with the data line toggling
    for (int i = 0; i < 8; i++) begin
      contREAD = ~contREAD;
      cycle();
    end
    cur_byte = byte_for(0);
    b = cur_byte;
    contREAD = ~b[0];
    NSYSRESET = 1'b1;

    while (frame < N_FRAMES) begin
      cycle();
      if (frame == RST_FRAME && o == 3*HB*2 + 1 && NSYSRESET) begin
        // Mid third shift-clock pulse: asynchronous abort
        #20 NSYSRESET = 1'b0;
        #1;
        check("async_write", 32'(contWRITE), 32'd0);
        check("async_rdata", 32'(RDATA), 32'd0);
        repeat (3) cycle();
        frame++;
        cur_byte = byte_for(frame);
        b = cur_byte;
        contREAD = ~b[0];
        exp_rdata = 8'h00;
        t = 0;
        NSYSRESET = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
